spi_slave: RTL

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/spi_slave.sv
// SPI slave with clk-domain oversampling of sclk/csn/mosi.
// Handshake: there is no valid/ready pair. spi_done is a one-clk strobe that
// marks data_recv as freshly updated; data_send is captured at frame start
// and at each word completion, so the host must hold it stable around those
// points. busy reflects the FSM state (high only in ACTIVE).
module spi_slave #(
  parameter int DATA_WIDTH = 8,
  parameter int CPOL       = 0,
  parameter int CPHA       = 0
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  sclk,
  input  logic                  csn,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] data_send,
  output logic [DATA_WIDTH-1:0] data_recv,
  output logic                  spi_done,
  output logic                  busy
);

  localparam int                CNT_W     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
  localparam logic              SCLK_IDLE = (CPOL != 0);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic sclk_s1, sclk_s2, sclk_s3;
  logic csn_s1, csn_s2;
  logic mosi_s1, mosi_s2;
  logic [1:0] sync_vld;
  logic armed;

  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] rx_sr;
  logic [DATA_WIDTH-1:0] tx_sr;
  logic [DATA_WIDTH-1:0] rx_next;

  logic rise, fall, lead_edge, trail_edge, sample_edge, shift_edge;
  logic start, cs_release, do_sample, do_shift, word_end;

  // Synchronize the SPI pins; sclk gets a third stage for edge detection.
  // sync_vld marks when csn_s2 reflects the pin rather than its reset value,
  // and armed records that csn has been seen high since reset.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      sclk_s1  <= SCLK_IDLE;
      sclk_s2  <= SCLK_IDLE;
      sclk_s3  <= SCLK_IDLE;
      csn_s1   <= 1'b1;
      csn_s2   <= 1'b1;
      mosi_s1  <= 1'b0;
      mosi_s2  <= 1'b0;
      sync_vld <= 2'b00;
      armed    <= 1'b0;
    end else begin
      sclk_s1  <= sclk;
      sclk_s2  <= sclk_s1;
      sclk_s3  <= sclk_s2;
      csn_s1   <= csn;
      csn_s2   <= csn_s1;
      mosi_s1  <= mosi;
      mosi_s2  <= mosi_s1;
      sync_vld <= {sync_vld[0], 1'b1};
      if (sync_vld[1] && csn_s2) begin
        armed <= 1'b1;
      end
    end
  end

  assign rise        = sclk_s2 & ~sclk_s3;
  assign fall        = ~sclk_s2 & sclk_s3;
  assign lead_edge   = (CPOL == 0) ? rise : fall;
  assign trail_edge  = (CPOL == 0) ? fall : rise;
  assign sample_edge = (CPHA == 0) ? lead_edge : trail_edge;
  assign shift_edge  = (CPHA == 0) ? trail_edge : lead_edge;

  assign rx_next  = {rx_sr[DATA_WIDTH-2:0], mosi_s2};
  assign word_end = do_sample && (bit_cnt == LAST_BIT);

  // FSM state register.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and datapath strobes; csn release outranks any sclk edge.
  always_comb begin
    state_d    = state_q;
    start      = 1'b0;
    cs_release = 1'b0;
    do_sample  = 1'b0;
    do_shift   = 1'b0;
    case (state_q)
      IDLE: begin
        if (armed && !csn_s2) begin
          state_d = ACTIVE;
          start   = 1'b1;
        end
      end
      ACTIVE: begin
        if (csn_s2) begin
          state_d    = IDLE;
          cs_release = 1'b1;
        end else begin
          do_sample = sample_edge;
          do_shift  = shift_edge;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shift registers, bit counter, received word and completion strobe.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      bit_cnt   <= '0;
      rx_sr     <= '0;
      tx_sr     <= '0;
      miso      <= 1'b0;
      data_recv <= '0;
      spi_done  <= 1'b0;
    end else begin
      spi_done <= 1'b0;
      if (start) begin
        bit_cnt <= '0;
        if (CPHA == 0) begin
          miso  <= data_send[DATA_WIDTH-1];
          tx_sr <= data_send << 1;
        end else begin
          tx_sr <= data_send;
        end
      end else if (cs_release) begin
        bit_cnt <= '0;
      end else begin
        if (do_sample) begin
          rx_sr <= rx_next;
          if (word_end) begin
            bit_cnt   <= '0;
            data_recv <= rx_next;
            spi_done  <= 1'b1;
            tx_sr     <= data_send;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        if (do_shift) begin
          miso  <= tx_sr[DATA_WIDTH-1];
          tx_sr <= tx_sr << 1;
        end
      end
    end
  end

  assign miso_oe = ~csn_s2;
  assign busy    = (state_q == ACTIVE);

endmodule
